// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and BCD constants for the serial BCD subtractor.
package bcd_pkg;
    typedef enum logic [1:0] {IDLE, SUB, RECOMP, FIN} state_t;
    localparam int BCD_DIGIT_W = 4;
    localparam logic [4:0] BCD_TEN = 5'd10;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
endpackage

// File: rtl/bcd_digit_sub.sv
// bcd_digit_sub: one BCD digit of a - b - bi with borrow out and invalid-digit flag.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bi,
    output logic [3:0] d,
    output logic       bo,
    output logic       bad
);
    logic [4:0] w_t;
    logic [4:0] w_adj;
    assign w_t   = {1'b0, a} - {1'b0, b} - {4'b0, bi};
    assign w_adj = w_t + BCD_TEN;
    assign bo    = w_t[4];
    assign d     = bo ? w_adj[3:0] : w_t[3:0];
    assign bad   = (a > BCD_MAX_DIGIT) | (b > BCD_MAX_DIGIT);
endmodule

// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial: digit-serial packed-BCD subtractor D = A - B - BIN, LSD first.
// Define BCD_SUB_SIGN_MAG_EN to return sign/magnitude instead of ten's complement.
module bcd_sub_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   D,
    output logic                  BOUT,
    output logic                  ERR
);
    localparam int W  = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_a, r_b, r_w, r_d;
    logic            r_bor, r_err, r_bout, r_err_o;
    logic [3:0]      w_da, w_db, w_dig;
    logic            w_bo, w_bad, w_last;
    logic [W-1:0]    w_next;
    // RECOMP negates the partial result in place: 0 - D_i - borrow.
    assign w_da   = (r_state == RECOMP) ? 4'd0 : r_a[3:0];
    assign w_db   = (r_state == RECOMP) ? r_w[3:0] : r_b[3:0];
    assign w_last = r_cnt == CW'(DIGITS - 1);
    assign w_next = (r_w >> BCD_DIGIT_W) | (W'(w_dig) << (W - BCD_DIGIT_W));
    bcd_digit_sub u_dig (.a(w_da), .b(w_db), .bi(r_bor), .d(w_dig), .bo(w_bo), .bad(w_bad));
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_w     <= '0;
            r_d     <= '0;
            r_bor   <= 1'b0;
            r_err   <= 1'b0;
            r_bout  <= 1'b0;
            r_err_o <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (START) begin
                    r_a     <= A;
                    r_b     <= B;
                    r_w     <= '0;
                    r_bor   <= BIN;
                    r_err   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= SUB;
                end
                SUB: begin
                    r_a   <= r_a >> BCD_DIGIT_W;
                    r_b   <= r_b >> BCD_DIGIT_W;
                    r_w   <= w_next;
                    r_bor <= w_bo;
                    r_err <= r_err | w_bad;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
`ifdef BCD_SUB_SIGN_MAG_EN
                        if (w_bo) begin
                            r_state <= RECOMP;
                            r_bor   <= 1'b0;
                            r_cnt   <= '0;
                        end else
`endif
                        begin
                            r_state <= FIN;
                            r_d     <= w_next;
                            r_bout  <= w_bo;
                            r_err_o <= r_err | w_bad;
                        end
                    end
                end
`ifdef BCD_SUB_SIGN_MAG_EN
                RECOMP: begin
                    r_w   <= w_next;
                    r_bor <= w_bo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= FIN;
                        r_d     <= w_next;
                        r_bout  <= 1'b1;
                        r_err_o <= r_err;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end
    assign BUSY = (r_state == SUB) | (r_state == RECOMP);
    assign DONE = r_state == FIN;
    assign D    = r_d;
    assign BOUT = r_bout;
    assign ERR  = r_err_o;
endmodule
